// File: rtl/button_event_pkg.sv
// Shared types and default parameters for the button event decoder.
//  - state_e: hold-classification FSM states
//  - *_DEF localparams: default tick counts and press counter width
package button_event_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHORT = 2'd1,
    S_LONG  = 2'd2
  } state_e;

  localparam int LONG_TICKS_DEF   = 4;
  localparam int REPEAT_TICKS_DEF = 2;
  localparam int CNT_W_DEF        = 8;

endpackage

// File: rtl/button_event_decoder_edge_det.sv
// Registered-level edge detector.
// Ports:
//  clk_i   in  1  clock, rising edge
//  rst_i   in  1  asynchronous active-high reset; level register loads RST_VAL
//  d_i     in  1  level input, synchronous to clk_i
//  rise_o  out 1  d_i & ~d_q (combinational from the registered level)
//  fall_o  out 1  ~d_i & d_q
// RST_VAL=1 lets a level that is already high through reset produce no rise.
module edge_det #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic d_q_r;

  // One-cycle delayed copy of the input level.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      d_q_r <= RST_VAL;
    end else begin
      d_q_r <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q_r;
  assign fall_o = ~d_i & d_q_r;

endmodule

// File: rtl/button_event_decoder.sv
// Button event decoder: turns the debounced level and debounce tick into
// press/release pulses, a long-press pulse, auto-repeat pulses and a
// wrapping press counter.
// Ports:
//  clk_i      in   1      clock, rising edge
//  rst_i      in   1      asynchronous active-high reset
//  db_i       in   1      debounced switch level
//  m_tick_i   in   1      debounce tick, 1-cycle pulse
//  cnt_clr_i  in   1      synchronous clear of count_o (wins over a press)
//  press_o    out  1      1-cycle pulse on accepted press
//  release_o  out  1      1-cycle pulse on release
//  long_o     out  1      1-cycle pulse when hold reaches LONG_TICKS ticks
//  repeat_o   out  1      1-cycle pulse every REPEAT_TICKS ticks in long state
//  held_o     out  1      high while FSM is not idle
//  count_o    out  CNT_W  accepted presses modulo 2**CNT_W
module button_event_decoder
  import button_event_pkg::*;
#(
  parameter int LONG_TICKS   = LONG_TICKS_DEF,
  parameter int REPEAT_TICKS = REPEAT_TICKS_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             db_i,
  input  logic             m_tick_i,
  input  logic             cnt_clr_i,
  output logic             press_o,
  output logic             release_o,
  output logic             long_o,
  output logic             repeat_o,
  output logic             held_o,
  output logic [CNT_W-1:0] count_o
);

  localparam int MAX_LR = (LONG_TICKS > REPEAT_TICKS) ? LONG_TICKS : REPEAT_TICKS;
  localparam int TW     = $clog2((MAX_LR > 2) ? MAX_LR : 2);

  localparam logic [TW-1:0] LONG_LAST = TW'(LONG_TICKS - 1);
  localparam logic [TW-1:0] REP_LAST  = (REPEAT_TICKS == 0) ? {TW{1'b0}} : TW'(REPEAT_TICKS - 1);
  localparam logic          REP_EN    = (REPEAT_TICKS != 0);

  state_e           state_r;
  logic [TW-1:0]    tick_cnt_r;
  logic             press_r;
  logic             release_r;
  logic             long_r;
  logic             repeat_r;
  logic             held_r;
  logic [CNT_W-1:0] count_r;
  logic             rise_s;
  logic             fall_s;

  // db_q resets high so a switch held through reset needs a full release/press.
  edge_det #(
    .RST_VAL (1'b1)
  ) u_edge_det (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (db_i),
    .rise_o (rise_s),
    .fall_o (fall_s)
  );

  // Hold-classification FSM with tick counter and registered event pulses.
  // In S_SHORT/S_LONG the previous cycle's db_i was necessarily 1, so
  // fall_s is exactly ~db_i there; release takes priority over a tick.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r    <= S_IDLE;
      tick_cnt_r <= {TW{1'b0}};
      press_r    <= 1'b0;
      release_r  <= 1'b0;
      long_r     <= 1'b0;
      repeat_r   <= 1'b0;
      held_r     <= 1'b0;
    end else begin
      press_r   <= 1'b0;
      release_r <= 1'b0;
      long_r    <= 1'b0;
      repeat_r  <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (rise_s) begin
            state_r    <= S_SHORT;
            press_r    <= 1'b1;
            held_r     <= 1'b1;
            tick_cnt_r <= {TW{1'b0}};
          end else begin
            held_r <= 1'b0;
          end
        end
        S_SHORT: begin
          if (fall_s) begin
            state_r    <= S_IDLE;
            release_r  <= 1'b1;
            held_r     <= 1'b0;
            tick_cnt_r <= {TW{1'b0}};
          end else if (m_tick_i) begin
            held_r <= 1'b1;
            if (tick_cnt_r == LONG_LAST) begin
              state_r    <= S_LONG;
              long_r     <= 1'b1;
              tick_cnt_r <= {TW{1'b0}};
            end else begin
              tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
          end else begin
            held_r <= 1'b1;
          end
        end
        S_LONG: begin
          if (fall_s) begin
            state_r    <= S_IDLE;
            release_r  <= 1'b1;
            held_r     <= 1'b0;
            tick_cnt_r <= {TW{1'b0}};
          end else if (m_tick_i && REP_EN) begin
            held_r <= 1'b1;
            if (tick_cnt_r == REP_LAST) begin
              repeat_r   <= 1'b1;
              tick_cnt_r <= {TW{1'b0}};
            end else begin
              tick_cnt_r <= tick_cnt_r + {{(TW-1){1'b0}}, 1'b1};
            end
          end else begin
            held_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= S_IDLE;
          held_r     <= 1'b0;
          tick_cnt_r <= {TW{1'b0}};
        end
      endcase
    end
  end

  // Press counter: clear beats a coincident press; wraps naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if (cnt_clr_i) begin
      count_r <= {CNT_W{1'b0}};
    end else if ((state_r == S_IDLE) && rise_s) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign press_o   = press_r;
  assign release_o = release_r;
  assign long_o    = long_r;
  assign repeat_o  = repeat_r;
  assign held_o    = held_r;
  assign count_o   = count_r;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed testbench for button_event_decoder (LONG_TICKS=4, REPEAT_TICKS=2,
// CNT_W=8). Inputs change on the falling edge; outputs are sampled 1ns after
// the rising edge that follows. Output vector order:
// {press, release, long, repeat, held}.
module tb_button_event_decoder;

  logic       clk;
  logic       rst;
  logic       db;
  logic       m_tick;
  logic       cnt_clr;
  logic       press;
  logic       rel;
  logic       lng;
  logic       rpt;
  logic       held;
  logic [7:0] count;

  int n_assert = 0;
  int n_fail   = 0;

  button_event_decoder #(
    .LONG_TICKS   (4),
    .REPEAT_TICKS (2),
    .CNT_W        (8)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .db_i      (db),
    .m_tick_i  (m_tick),
    .cnt_clr_i (cnt_clr),
    .press_o   (press),
    .release_o (rel),
    .long_o    (lng),
    .repeat_o  (rpt),
    .held_o    (held),
    .count_o   (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs at the falling edge, then sample just after the rising edge.
  task automatic step(input logic d, input logic t, input logic c);
    @(negedge clk);
    db      = d;
    m_tick  = t;
    cnt_clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {press, rel, lng, rpt, held};
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: outs observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [7:0] exp);
    n_assert++;
    assert (count === exp) else begin
      n_fail++;
      $error("FAIL %s: count observed %0d expected %0d", tag, count, exp);
    end
  endtask

  initial begin
    logic [4:0] long_exp [1:8];
    long_exp[1] = 5'b00001;
    long_exp[2] = 5'b00001;
    long_exp[3] = 5'b00001;
    long_exp[4] = 5'b00101;
    long_exp[5] = 5'b00001;
    long_exp[6] = 5'b00011;
    long_exp[7] = 5'b00001;
    long_exp[8] = 5'b00011;

    rst = 1'b1; db = 1'b0; m_tick = 1'b0; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset_outs", 5'b00000);
    chk_cnt("reset_cnt", 8'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b0);
      chk_outs("post_reset_idle", 5'b00000);
    end
    chk_cnt("post_reset_cnt", 8'd0);

    // Short press: two ticks then release.
    step(1'b1, 1'b0, 1'b0);
    chk_outs("short_press", 5'b10001);
    chk_cnt("short_cnt", 8'd1);
    step(1'b1, 1'b1, 1'b0);
    chk_outs("short_tick1", 5'b00001);
    step(1'b1, 1'b1, 1'b0);
    chk_outs("short_tick2", 5'b00001);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("short_release", 5'b01000);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("short_after", 5'b00000);

    // Long press with auto-repeat.
    step(1'b1, 1'b0, 1'b0);
    chk_outs("long_press", 5'b10001);
    chk_cnt("long_cnt", 8'd2);
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_outs("long_tick", long_exp[i]);
    end
    step(1'b1, 1'b0, 1'b0);
    chk_outs("long_hold_quiet", 5'b00001);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("long_release", 5'b01000);

    // Release coincident with the 4th tick: release wins, no long.
    step(1'b1, 1'b0, 1'b0);
    chk_outs("race_press", 5'b10001);
    chk_cnt("race_cnt", 8'd3);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1, 1'b0);
      chk_outs("race_tick", 5'b00001);
    end
    step(1'b0, 1'b1, 1'b0);
    chk_outs("race_release", 5'b01000);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("race_idle", 5'b00000);

    // Counter wrap: 3 + 252 = 255, one more wraps to 0.
    for (int i = 0; i < 252; i++) begin
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
    end
    chk_cnt("cnt_255", 8'd255);
    step(1'b1, 1'b0, 1'b0);
    chk_outs("wrap_press", 5'b10001);
    chk_cnt("cnt_wrap", 8'd0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_cnt("cnt_after_wrap", 8'd1);
    step(1'b0, 1'b0, 1'b0);

    // Clear coincident with press: clear wins, press still pulses.
    step(1'b1, 1'b0, 1'b1);
    chk_outs("clr_press", 5'b10001);
    chk_cnt("clr_cnt", 8'd0);

    // Reset while held: immediate clear, no release, no press afterwards.
    @(negedge clk);
    cnt_clr = 1'b0;
    rst = 1'b1;
    #1;
    chk_outs("midhold_reset_async", 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0);
      chk_outs("held_through_reset", 5'b00000);
    end
    chk_cnt("held_reset_cnt", 8'd0);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("held_reset_fall", 5'b00000);
    step(1'b1, 1'b0, 1'b0);
    chk_outs("repress", 5'b10001);
    chk_cnt("repress_cnt", 8'd1);
    step(1'b1, 1'b0, 1'b0);
    chk_outs("repress_hold", 5'b00001);
    step(1'b0, 1'b0, 1'b0);
    chk_outs("repress_release", 5'b01000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
